// File: rtl/bnn_seq_pkg.sv
// Shared types and constants for the BNN run sequencer: FSM state encoding,
// default bus widths and the fixed SRAM header layout.
package bnn_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;

  // Word 0 of each memory holds the vector count; vectors follow from word 1.
  localparam int HDR_ADDR  = 0;
  localparam int DATA_BASE = 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR_RD = 4'd1,
    S_HDR_LD = 4'd2,
    S_RD     = 4'd3,
    S_LD     = 4'd4,
    S_ISSUE  = 4'd5,
    S_WAIT   = 4'd6,
    S_WR     = 4'd7,
    S_DONE   = 4'd8
  } state_e;

endpackage

// File: rtl/bnn_run_sequencer.sv
// Job controller for the BNN accelerator: reads N/M headers, walks every
// (input, weight) pair through the datapath and writes results row-major.
module bnn_run_sequencer
  import bnn_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  dut_run,
  output logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
  input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
  output logic [ADDR_WIDTH-1:0] dut_wmem_read_address,
  input  logic [DATA_WIDTH-1:0] wmem_dut_read_data,
  output logic                  dut_sram_write_enable,
  output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
  output logic [DATA_WIDTH-1:0] dut_sram_write_data,
  output logic                  seq_dp_start,
  output logic [DATA_WIDTH-1:0] seq_dp_x,
  output logic [DATA_WIDTH-1:0] seq_dp_w,
  input  logic                  dp_seq_done,
  input  logic [DATA_WIDTH-1:0] dp_seq_result
);

  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(DATA_BASE);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] n_q, n_d, m_q, m_d;
  logic [DATA_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [DATA_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, w_q, w_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d, wt_addr_q, wt_addr_d;
  logic                  busy_q, busy_d, start_q, start_d, we_q, we_d;

  logic last_j, last_pair, hdr_empty;

  assign last_j    = (j_q == m_q - ONE);
  assign last_pair = last_j && (i_q == n_q - ONE);
  assign hdr_empty = (sram_dut_read_data == '0) || (wmem_dut_read_data == '0);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (dut_run) state_d = S_HDR_RD;
      S_HDR_RD: state_d = S_HDR_LD;
      S_HDR_LD: state_d = hdr_empty ? S_DONE : S_RD;
      S_RD:     state_d = S_LD;
      S_LD:     state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (dp_seq_done) state_d = S_WR;
      S_WR:     state_d = last_pair ? S_DONE : S_RD;
      // Wait for run to drop so a held request cannot retrigger the job.
      S_DONE:   if (!dut_run) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe and bus lines
  // up with the cycle the FSM spends in the corresponding state.
  always_comb begin
    n_d       = n_q;
    m_d       = m_q;
    i_d       = i_q;
    j_d       = j_q;
    wcnt_d    = wcnt_q;
    x_d       = x_q;
    w_d       = w_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    in_addr_d = in_addr_q;
    wt_addr_d = wt_addr_q;

    case (state_q)
      S_HDR_LD: begin
        n_d    = sram_dut_read_data;
        m_d    = wmem_dut_read_data;
        i_d    = '0;
        j_d    = '0;
        wcnt_d = '0;
      end
      S_LD: begin
        x_d = sram_dut_read_data;
        w_d = wmem_dut_read_data;
      end
      S_WAIT: begin
        if (dp_seq_done) begin
          wdata_d = dp_seq_result;
          waddr_d = ADDR_WIDTH'(wcnt_q);
        end
      end
      S_WR: begin
        wcnt_d = wcnt_q + ONE;
        if (last_j) begin
          j_d = '0;
          i_d = i_q + ONE;
        end else begin
          j_d = j_q + ONE;
        end
      end
      default: ;
    endcase

    if (state_d == S_HDR_RD) begin
      in_addr_d = ADDR_WIDTH'(HDR_ADDR);
      wt_addr_d = ADDR_WIDTH'(HDR_ADDR);
    end else if (state_d == S_RD) begin
      in_addr_d = ADDR_WIDTH'(i_d + BASE);
      wt_addr_d = ADDR_WIDTH'(j_d + BASE);
    end

    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    start_d = (state_d == S_ISSUE);
    we_d    = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      n_q       <= '0;
      m_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      wcnt_q    <= '0;
      x_q       <= '0;
      w_q       <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      in_addr_q <= '0;
      wt_addr_q <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      n_q       <= n_d;
      m_q       <= m_d;
      i_q       <= i_d;
      j_q       <= j_d;
      wcnt_q    <= wcnt_d;
      x_q       <= x_d;
      w_q       <= w_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      in_addr_q <= in_addr_d;
      wt_addr_q <= wt_addr_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      we_q      <= we_d;
    end
  end

  assign dut_busy               = busy_q;
  assign dut_sram_read_address  = in_addr_q;
  assign dut_wmem_read_address  = wt_addr_q;
  assign dut_sram_write_enable  = we_q;
  assign dut_sram_write_address = waddr_q;
  assign dut_sram_write_data    = wdata_q;
  assign seq_dp_start           = start_q;
  assign seq_dp_x               = x_q;
  assign seq_dp_w               = w_q;

endmodule

// File: tb/tb_bnn_run_sequencer.sv
// Scoreboard bench for bnn_run_sequencer: SRAM models, an x^w datapath stub
// with programmable latency, and a write monitor checked against a pair model.
module tb_bnn_run_sequencer;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          dut_run;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [DW-1:0] sram_dut_read_data;
  logic [AW-1:0] dut_wmem_read_address;
  logic [DW-1:0] wmem_dut_read_data;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;
  logic          seq_dp_start;
  logic [DW-1:0] seq_dp_x;
  logic [DW-1:0] seq_dp_w;
  logic          dp_seq_done;
  logic [DW-1:0] dp_seq_result;

  always #5 clk = ~clk;

  bnn_run_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .seq_dp_start           (seq_dp_start),
    .seq_dp_x               (seq_dp_x),
    .seq_dp_w               (seq_dp_w),
    .dp_seq_done            (dp_seq_done),
    .dp_seq_result          (dp_seq_result)
  );

  // Memories with one-cycle registered read.
  logic [DW-1:0] in_mem [0:4095];
  logic [DW-1:0] w_mem  [0:4095];

  always @(posedge clk) begin
    sram_dut_read_data <= in_mem[dut_sram_read_address];
    wmem_dut_read_data <= w_mem[dut_wmem_read_address];
  end

  // Datapath stub: result x^w, done pulse L cycles after the start cycle.
  int            lat = 1;
  int            st_cnt;
  logic          st_done;
  logic [DW-1:0] st_res;
  logic          spur = 1'b0;
  bit            spur_en = 1'b0;

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      st_cnt  <= 0;
      st_done <= 1'b0;
      st_res  <= '0;
    end else if (seq_dp_start) begin
      st_cnt  <= lat - 1;
      st_done <= (lat == 1);
      st_res  <= seq_dp_x ^ seq_dp_w;
    end else if (st_cnt > 0) begin
      st_cnt  <= st_cnt - 1;
      st_done <= (st_cnt == 1);
    end else begin
      st_done <= 1'b0;
    end
  end

  assign dp_seq_done   = st_done | spur;
  assign dp_seq_result = st_res;

  // Spurious done for the whole cycle following each write strobe (the RD cycle).
  initial begin
    forever begin
      @(negedge clk);
      if (spur_en && dut_sram_write_enable && reset_b) begin
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  busy_cnt = 0;
  int  wr_seen  = 0;
  int  last_wr  = 0;
  bit  last_valid = 1'b0;
  int  spacing_exp = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: pops one expected write per observed strobe.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (dut_busy) busy_cnt++;
      if (dut_sram_write_enable) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {dut_sram_write_address, dut_sram_write_data}, '0);
        end else begin
          exp_e = exp_q.pop_front();
          chk("wr_addr", dut_sram_write_address, exp_e.a);
          chk("wr_data", dut_sram_write_data, exp_e.d);
        end
        if (spacing_exp != 0 && last_valid) chk("pair_spacing", cyc - last_wr, spacing_exp);
        last_wr    = cyc;
        last_valid = 1'b1;
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return {dut_busy, dut_sram_write_enable, seq_dp_start, dut_sram_read_address,
            dut_wmem_read_address, dut_sram_write_address, dut_sram_write_data,
            seq_dp_x, seq_dp_w};
  endfunction

  // Loads a job into the memories and queues the row-major x^w results.
  task automatic load_job(input int n, input int m);
    in_mem[0] = DW'(n);
    w_mem[0]  = DW'(m);
    for (int i = 0; i < n; i++) in_mem[1 + i] = DW'($urandom);
    for (int j = 0; j < m; j++) w_mem[1 + j] = DW'($urandom);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++) begin
        wr_t e;
        e.a = AW'((i * m + j) % 4096);
        e.d = in_mem[1 + i] ^ w_mem[1 + j];
        exp_q.push_back(e);
      end
  endtask

  task automatic run_job(input int n, input int m, input int l, input bit hold, input bit spur_on);
    int k;
    int limit;
    int exp_busy;
    int held_hi;
    exp_busy    = 2 + n * m * (4 + l);
    limit       = exp_busy + 20;
    lat         = l;
    spacing_exp = 4 + l;
    last_valid  = 1'b0;
    spur_en     = spur_on;
    busy_cnt    = 0;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    chk("start_latency", dut_busy, 1'b1);
    if (!hold) dut_run = 1'b0;
    k = 0;
    while (dut_busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("busy_timeout", (k < limit), 1'b1);
    @(negedge clk);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
    spur_en = 1'b0;
    if (hold) begin
      held_hi = 0;
      repeat (12) begin
        @(negedge clk);
        if (dut_busy) held_hi++;
      end
      chk("held_run_no_restart", held_hi, 0);
      dut_run = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_job();
    int k;
    load_job(2, 3);
    lat         = 3;
    spacing_exp = 7;
    last_valid  = 1'b0;
    wr_seen     = 0;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    k = 0;
    while (wr_seen < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    while (!seq_dp_start && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reset_reach_wait", (k < 200), 1'b1);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    chk("mid_reset_outputs_zero", all_outs(), '0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_reset_no_write", wr_seen, 2);
    chk("mid_reset_idle", dut_busy, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      in_mem[a] = '0;
      w_mem[a]  = '0;
    end
    reset_b = 1'b0;
    dut_run = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", all_outs(), '0);
    reset_b = 1'b1;
    @(negedge clk);

    // Directed basic job.
    in_mem[0] = 16'd2; in_mem[1] = 16'hA5A5; in_mem[2] = 16'h0F0F;
    w_mem[0]  = 16'd3; w_mem[1]  = 16'h0001; w_mem[2]  = 16'h00FF; w_mem[3] = 16'hFFFF;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        wr_t e;
        e.a = AW'(i * 3 + j);
        e.d = in_mem[1 + i] ^ w_mem[1 + j];
        exp_q.push_back(e);
      end
    run_job(2, 3, 1, 1'b0, 1'b0);

    load_job(0, 4); run_job(0, 4, 1, 1'b0, 1'b0);
    load_job(3, 0); run_job(3, 0, 2, 1'b0, 1'b0);

    load_job(2, 2); run_job(2, 2, 2, 1'b1, 1'b0);
    load_job(3, 1); run_job(3, 1, 1, 1'b0, 1'b0);

    load_job(3, 3); run_job(3, 3, 5, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      int n, m, l;
      n = $urandom_range(1, 5);
      m = $urandom_range(1, 5);
      l = $urandom_range(1, 6);
      load_job(n, m);
      run_job(n, m, l, 1'b0, ($urandom_range(0, 1) == 1));
    end

    reset_mid_job();
    load_job(2, 3); run_job(2, 3, 2, 1'b0, 1'b0);

    load_job(65, 64); run_job(65, 64, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
